prog_interval_timer: RTL and testbench

- Parametrised interval timer generating a single-cycle `tick` every `period` clock cycles.
- Supports one-shot, periodic and burst modes, a runtime-loadable period, and pause/resume.
- Supersedes the fixed half-second enable-held timer.
- Used by IR receiver timeouts, LED/buzzer cadence and sampling strobes on the 50 MHz system clock.

---
 rtl/prog_interval_timer.sv | 109 ++++++++++
 tb/tb_prog_interval_timer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_interval_timer.sv
// Programmable interval timer: one-cycle tick every period_q cycles with one-shot,
// periodic and burst modes, runtime period load and pause/resume.
module prog_interval_timer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = 25_000_000,
  parameter int unsigned BURST_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               pause,
  input  logic               load,
  input  logic [WIDTH-1:0]   period_in,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               done,
  output logic               busy,
  output logic [WIDTH-1:0]   counter,
  output logic [BURST_W-1:0] tick_count
);

  localparam logic [WIDTH-1:0] DefPeriod = WIDTH'(DEFAULT_PERIOD);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [BURST_W-1:0] burst_q;
  logic [WIDTH-1:0]   period_q;

  logic [WIDTH-1:0]   load_val;
  logic [BURST_W-1:0] tc_inc;
  logic               terminal;
  logic               finish;

  always_comb begin
    load_val = (period_in == '0) ? WIDTH'(1) : period_in;
    terminal = (counter == period_q - WIDTH'(1));
    tc_inc   = (&tick_count) ? tick_count : tick_count + BURST_W'(1);
    // Mode 11 falls through as periodic: neither condition matches.
    finish   = (mode_q == 2'b00) || ((mode_q == 2'b10) && (tc_inc == burst_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= 2'b01;
      burst_q    <= BURST_W'(1);
      period_q   <= DefPeriod;
      counter    <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      tick_count <= '0;
    end else begin
      if (load) period_q <= load_val;
      tick <= 1'b0;
      if (!enable) begin
        state_q    <= StIdle;
        counter    <= '0;
        done       <= 1'b0;
        busy       <= 1'b0;
        tick_count <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            counter    <= '0;
            tick_count <= '0;
            mode_q     <= mode;
            burst_q    <= (burst_len == '0) ? BURST_W'(1) : burst_len;
            busy       <= 1'b1;
            state_q    <= StRun;
          end
          StRun, StPaused: begin
            // Terminal count wins over a pause arriving in RUN, so the tick still fires.
            if (terminal && ((state_q == StRun) || !pause)) begin
              tick       <= 1'b1;
              counter    <= '0;
              tick_count <= tc_inc;
              if (finish) begin
                state_q <= StDone;
                done    <= 1'b1;
                busy    <= 1'b0;
              end else begin
                state_q <= pause ? StPaused : StRun;
              end
            end else if (load && (load_val <= counter)) begin
              counter <= '0;
              state_q <= pause ? StPaused : StRun;
            end else if (pause) begin
              state_q <= StPaused;
            end else begin
              counter <= counter + WIDTH'(1);
              state_q <= StRun;
            end
          end
          StDone: begin
            counter <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_interval_timer.sv
// Directed bench for prog_interval_timer with a reduced default period of 8.
module tb_prog_interval_timer;

  localparam int unsigned W  = 16;
  localparam int unsigned BW = 4;

  logic          clk, rst_n, enable, pause, load;
  logic [1:0]    mode;
  logic [W-1:0]  period_in;
  logic [BW-1:0] burst_len;
  logic          tick, done, busy;
  logic [W-1:0]  counter;
  logic [BW-1:0] tick_count;

  int checks   = 0;
  int failures = 0;

  prog_interval_timer #(
    .WIDTH         (W),
    .DEFAULT_PERIOD(8),
    .BURST_W       (BW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .pause     (pause),
    .load      (load),
    .period_in (period_in),
    .burst_len (burst_len),
    .tick      (tick),
    .done      (done),
    .busy      (busy),
    .counter   (counter),
    .tick_count(tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stop();
    enable = 1'b0; load = 1'b0; pause = 1'b0;
    step();
    step();
  endtask

  // Start with a load in the same cycle as IDLE->RUN; returns after edge 0.
  task automatic start(input logic [1:0] m, input int p, input int bl);
    mode = m; period_in = W'(p); burst_len = BW'(bl); load = 1'b1; enable = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pause = 1'b0; load = 1'b0;
    mode = 2'b01; period_in = '0; burst_len = '0;
    #2;
    checks++;
    if ({tick, done, busy, counter, tick_count} !== '0) begin
      $display("FAIL reset_outputs got=%h exp=0", {tick, done, busy, counter, tick_count});
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_periodic();
    start(2'b01, 5, 0);
    mode = 2'b00;  // must be ignored while busy
    checks++;
    if (counter !== 0 || busy !== 1'b1) begin
      $display("FAIL periodic_start cnt=%0d busy=%b exp cnt=0 busy=1", counter, busy);
      failures++;
    end
    for (int n = 1; n <= 15; n++) begin
      step();
      checks++;
      if (tick !== (n % 5 == 0) || counter !== W'(n % 5) || done !== 1'b0) begin
        $display("FAIL periodic n=%0d tick=%b cnt=%0d done=%b exp tick=%b cnt=%0d done=0",
                 n, tick, counter, done, (n % 5 == 0), n % 5);
        failures++;
      end
    end
    checks++;
    if (tick_count !== BW'(3)) begin
      $display("FAIL periodic_tick_count got=%0d exp=3", tick_count);
      failures++;
    end
    enable = 1'b0;
    step();
    checks++;
    if ({busy, counter, tick_count} !== '0) begin
      $display("FAIL periodic_disable busy=%b cnt=%0d tc=%0d exp all 0", busy, counter, tick_count);
      failures++;
    end
    stop();
  endtask

  task automatic test_oneshot();
    start(2'b00, 4, 0);
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (tick !== (n == 4) || done !== (n >= 4) || busy !== (n < 4) ||
          counter !== W'((n < 4) ? n : 0)) begin
        $display("FAIL oneshot n=%0d tick=%b done=%b busy=%b cnt=%0d exp tick=%b done=%b busy=%b",
                 n, tick, done, busy, counter, (n == 4), (n >= 4), (n < 4));
        failures++;
      end
    end
    enable = 1'b0;
    step();
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL oneshot_clear done got=%b exp=0", done);
      failures++;
    end
    stop();
  endtask

  task automatic test_burst();
    start(2'b10, 2, 3);
    for (int n = 1; n <= 9; n++) begin
      step();
      checks++;
      if (tick !== (n == 2 || n == 4 || n == 6) || done !== (n >= 6) ||
          tick_count !== BW'((n / 2 > 3) ? 3 : n / 2)) begin
        $display("FAIL burst n=%0d tick=%b done=%b tc=%0d exp done=%b tc=%0d",
                 n, tick, done, tick_count, (n >= 6), (n / 2 > 3) ? 3 : n / 2);
        failures++;
      end
    end
    stop();
  endtask

  task automatic test_pause();
    int ec;
    start(2'b01, 10, 0);
    for (int n = 1; n <= 20; n++) begin
      step();
      ec = (n <= 3) ? n : (n <= 10) ? 3 : (n - 7) % 10;
      checks++;
      if (tick !== (n == 17) || counter !== W'(ec)) begin
        $display("FAIL pause n=%0d tick=%b cnt=%0d exp tick=%b cnt=%0d",
                 n, tick, counter, (n == 17), ec);
        failures++;
      end
      pause = (n >= 3 && n <= 9);
    end
    stop();
  endtask

  task automatic test_pause_terminal();
    int ec;
    start(2'b01, 3, 0);
    for (int n = 1; n <= 7; n++) begin
      step();
      ec = (n <= 2) ? n : (n <= 5) ? 0 : n - 5;
      checks++;
      if (tick !== (n == 3) || counter !== W'(ec) || busy !== 1'b1) begin
        $display("FAIL pause_terminal n=%0d tick=%b cnt=%0d busy=%b exp tick=%b cnt=%0d busy=1",
                 n, tick, counter, busy, (n == 3), ec);
        failures++;
      end
      pause = (n >= 2 && n <= 4);
    end
    stop();
  endtask

  task automatic test_load_shrink();
    int ec;
    start(2'b01, 10, 0);
    for (int n = 1; n <= 11; n++) begin
      step();
      ec = (n <= 6) ? n : (n - 7) % 2;
      checks++;
      if (tick !== (n > 7 && (n - 7) % 2 == 0) || counter !== W'(ec)) begin
        $display("FAIL load_shrink n=%0d tick=%b cnt=%0d exp tick=%b cnt=%0d",
                 n, tick, counter, (n > 7 && (n - 7) % 2 == 0), ec);
        failures++;
      end
      load = (n == 6);
      period_in = W'(2);
    end
    stop();
  endtask

  task automatic test_load_terminal();
    int ec;
    start(2'b01, 4, 0);
    for (int n = 1; n <= 11; n++) begin
      step();
      ec = (n < 4) ? n : (n - 4) % 6;
      checks++;
      if (tick !== (n == 4 || n == 10) || counter !== W'(ec)) begin
        $display("FAIL load_terminal n=%0d tick=%b cnt=%0d exp tick=%b cnt=%0d",
                 n, tick, counter, (n == 4 || n == 10), ec);
        failures++;
      end
      load = (n == 3);
      period_in = W'(6);
    end
    stop();
  endtask

  task automatic test_period_zero();
    int et;
    start(2'b01, 0, 0);
    for (int n = 1; n <= 20; n++) begin
      step();
      et = (n > 15) ? 15 : n;
      checks++;
      if (tick !== 1'b1 || counter !== 0 || tick_count !== BW'(et)) begin
        $display("FAIL period_zero n=%0d tick=%b cnt=%0d tc=%0d exp tick=1 cnt=0 tc=%0d",
                 n, tick, counter, tick_count, et);
        failures++;
      end
    end
    stop();
  endtask

  task automatic test_async_reset();
    start(2'b01, 12, 0);
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tick, done, busy, counter, tick_count} !== '0) begin
      $display("FAIL async_reset got=%h exp=0", {tick, done, busy, counter, tick_count});
      failures++;
    end
    enable = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    mode = 2'b01; enable = 1'b1;
    step();
    for (int n = 1; n <= 16; n++) begin
      step();
      checks++;
      if (tick !== (n % 8 == 0) || counter !== W'(n % 8)) begin
        $display("FAIL default_period n=%0d tick=%b cnt=%0d exp tick=%b cnt=%0d",
                 n, tick, counter, (n % 8 == 0), n % 8);
        failures++;
      end
    end
    stop();
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_burst();
    test_pause();
    test_pause_terminal();
    test_load_shrink();
    test_load_terminal();
    test_period_zero();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
